// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller arbitrating instruction fetch and load/store ports
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        pred_fail_flag,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic        ls_enable,
    input  logic [2:0]  ls_siz,
    input  logic [31:0] ls_addr,
    input  logic        ls_wr_tag,
    input  logic [31:0] ls_din,
    output logic        ls_valid,
    output logic [31:0] ls_dout,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;
    logic [31:0] addr_q, din_q, rd_buf, rd_merged, next_addr;
    logic [2:0]  size_q, req_size;
    logic        if_valid_q, ls_valid_q;
    logic        accept_ls, accept_if, is_read, rd_last, if_abort;
    logic        io_stall, byte_issued, wr_last;
    logic [1:0]  rd_idx, wr_idx;

    always_comb begin
        req_size    = (ls_siz == 3'd1 || ls_siz == 3'd2) ? ls_siz : 3'd4;
        accept_ls   = (state == IDLE) && ls_enable;
        accept_if   = (state == IDLE) && !ls_enable && if_enable && !pred_fail_flag;
        is_read     = (state == IF_RD) || (state == LS_RD);
        rd_last     = is_read && (cnt == size_q);
        if_abort    = (state == IF_RD) && pred_fail_flag;
        // UART-mapped stores must wait until the IO buffer has room
        io_stall    = (state == LS_WR) && (addr_q[17:16] == 2'b11) && io_buffer_full;
        byte_issued = (state == LS_WR) && !io_stall;
        wr_last     = byte_issued && ((cnt + 3'd1) == size_q);
        rd_idx      = cnt[1:0] - 2'd1;
        wr_idx      = cnt[1:0] + 2'd1;
        next_addr   = addr_q + {29'd0, cnt} + 32'd1;
        // RAM read data trails the address by two edges, so byte cnt-1 arrives now
        rd_merged   = rd_buf;
        rd_merged[{rd_idx, 3'b000} +: 8] = ram_din;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept_ls) begin
                    state_next = ls_wr_tag ? LS_WR : LS_RD;
                    cnt_next   = 3'd0;
                end else if (accept_if) begin
                    state_next = IF_RD;
                    cnt_next   = 3'd0;
                end
            end
            IF_RD, LS_RD: begin
                if (if_abort)
                    state_next = IDLE;
                else if (rd_last)
                    state_next = DONE;
                else
                    cnt_next = cnt + 3'd1;
            end
            LS_WR: begin
                if (wr_last)
                    state_next = DONE;
                else if (byte_issued)
                    cnt_next = cnt + 3'd1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (rdy) begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= 32'd0;
            din_q      <= 32'd0;
            size_q     <= 3'd4;
            rd_buf     <= 32'd0;
            ram_a      <= 32'd0;
            ram_dout   <= 8'd0;
            if_data    <= 32'd0;
            ls_dout    <= 32'd0;
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
        end else if (rdy) begin
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
            if (accept_ls || accept_if) begin
                addr_q <= accept_ls ? ls_addr : if_addr;
                size_q <= accept_ls ? req_size : 3'd4;
                din_q  <= ls_din;
                rd_buf <= 32'd0;
                ram_a  <= accept_ls ? ls_addr : if_addr;
                if (accept_ls)
                    ram_dout <= ls_din[7:0];
            end
            if (is_read && !if_abort) begin
                if (cnt != 3'd0)
                    rd_buf <= rd_merged;
                if ((cnt + 3'd1) < size_q)
                    ram_a <= next_addr;
                if (rd_last) begin
                    if (state == IF_RD) begin
                        if_data    <= rd_merged;
                        if_valid_q <= 1'b1;
                    end else begin
                        ls_dout    <= rd_merged;
                        ls_valid_q <= 1'b1;
                    end
                end
            end
            if (byte_issued && !wr_last) begin
                ram_a    <= next_addr;
                ram_dout <= din_q[{wr_idx, 3'b000} +: 8];
            end
            if (wr_last)
                ls_valid_q <= 1'b1;
        end
    end

    // Strobe is gated live so a freeze or a full IO buffer never writes
    assign ram_wr   = (state == LS_WR) && rdy && !io_stall;
    assign ls_valid = ls_valid_q;
    assign if_valid = if_valid_q && !pred_fail_flag;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl directed scenarios
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        pred_fail_flag = 1'b0;
    logic        if_enable = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_valid;
    logic [31:0] if_data;
    logic        ls_enable = 1'b0;
    logic [2:0]  ls_siz = 3'd0;
    logic [31:0] ls_addr = 32'd0;
    logic        ls_wr_tag = 1'b0;
    logic [31:0] ls_din = 32'd0;
    logic        ls_valid;
    logic [31:0] ls_dout;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_buffer_full = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
    } exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_ls = 32'd0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  ram_q = 8'd0;
    int          wr_count = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .pred_fail_flag(pred_fail_flag),
        .if_enable(if_enable), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
        .ls_enable(ls_enable), .ls_siz(ls_siz), .ls_addr(ls_addr), .ls_wr_tag(ls_wr_tag),
        .ls_din(ls_din), .ls_valid(ls_valid), .ls_dout(ls_dout),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, one-cycle read latency, sharing the rdy enable with the core
    assign ram_din = ram_q;
    always @(posedge clk) begin
        if (rdy) begin
            if (ram_wr) begin
                mem[ram_a[15:0]] = ram_dout;
                wr_count <= wr_count + 1;
            end
            ram_q <= mem[ram_a[15:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && (if_valid || ls_valid)) begin
            check("valid_exclusive", {31'd0, if_valid && ls_valid}, 32'd0);
            check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("valid_port", {31'd0, if_valid}, {31'd0, mon_e.is_if});
                if (mon_e.is_if)
                    check("if_data", if_data, mon_e.data);
                else
                    check("ls_dout", ls_dout, mon_e.data);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] siz);
        logic [31:0] v;
        logic [31:0] ak;
        int          n;
        v = 32'd0;
        n = (siz == 3'd1 || siz == 3'd2) ? int'(siz) : 4;
        for (int k = 0; k < n; k++) begin
            ak = a + k;
            v[8*k +: 8] = mem[ak[15:0]];
        end
        return v;
    endfunction

    task automatic push_exp(input bit is_if, input logic [31:0] d);
        exp_t e;
        e.is_if = is_if;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic issue_ls(input bit wr, input logic [2:0] siz, input logic [31:0] a,
                            input logic [31:0] d, input bit track);
        ls_wr_tag = wr;
        ls_siz    = siz;
        ls_addr   = a;
        ls_din    = d;
        ls_enable = 1'b1;
        if (track) begin
            if (!wr)
                last_ls = load_val(a, siz);
            push_exp(1'b0, last_ls);
        end
        cyc(1);
        ls_enable = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("drain_sb", sb.size(), 0);
        sb.delete();
        cyc(2);
    endtask

    task automatic scan_valid(input int k0, input int k1, output int ls_k, output int if_k);
        ls_k = -1;
        if_k = -1;
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            if (ls_valid && ls_k < 0) ls_k = k;
            if (if_valid && if_k < 0) if_k = k;
            cyc(1);
        end
    endtask

    initial begin
        int          lk, ik, lk2, ik2, w0;
        logic [31:0] ea;
        logic [2:0]  tsiz [5];
        logic [31:0] taddr [5];

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
        mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
        mem[16'h0200] = 8'h55; mem[16'h0201] = 8'h66;

        #2 rst = 1'b0;
        #1;
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_ls_valid", {31'd0, ls_valid}, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_ram_a", ram_a, 32'd0);
        check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_ls_dout", ls_dout, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // LW 0x100: address walk then valid after the fifth edge
        issue_ls(1'b0, 3'd4, 32'h100, 32'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ea = 32'h100 + k;
            check("lw_ram_a", ram_a, ea);
            check("lw_ram_wr", {31'd0, ram_wr}, 32'd0);
            cyc(1);
        end
        scan_valid(4, 8, lk, ik);
        check("lw_valid_edge", lk, 5);
        wait_idle(20);

        tsiz[0] = 3'd1; taddr[0] = 32'h101;
        tsiz[1] = 3'd2; taddr[1] = 32'h102;
        tsiz[2] = 3'd3; taddr[2] = 32'h100;
        tsiz[3] = 3'd0; taddr[3] = 32'h100;
        tsiz[4] = 3'd7; taddr[4] = 32'h1FF;
        for (int i = 0; i < 5; i++) begin
            issue_ls(1'b0, tsiz[i], taddr[i], 32'd0, 1'b1);
            wait_idle(20);
        end

        w0 = wr_count;
        issue_ls(1'b1, 3'd4, 32'h400, 32'hDEADBEEF, 1'b1);
        wait_idle(20);
        check("sw_strobes", wr_count - w0, 4);
        check("sw_mem", {mem[16'h403], mem[16'h402], mem[16'h401], mem[16'h400]}, 32'hDEADBEEF);
        issue_ls(1'b0, 3'd4, 32'h400, 32'd0, 1'b1);
        wait_idle(20);

        w0 = wr_count;
        issue_ls(1'b1, 3'd2, 32'h410, 32'h12345678, 1'b1);
        wait_idle(20);
        check("sh_strobes", wr_count - w0, 2);
        check("sh_mem", {8'd0, mem[16'h412], mem[16'h411], mem[16'h410]},
              {8'd0, 8'h12 ^ 8'h5A, 8'h56, 8'h78});

        // SB to the UART window while its buffer is full
        w0 = wr_count;
        io_buffer_full = 1'b1;
        issue_ls(1'b1, 3'd1, 32'h30000, 32'h000000AB, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("io_stall_ram_wr", {31'd0, ram_wr}, 32'd0);
            cyc(1);
        end
        io_buffer_full = 1'b0;
        @(negedge clk);
        check("io_ram_wr", {31'd0, ram_wr}, 32'd1);
        check("io_ram_dout", {24'd0, ram_dout}, 32'h000000AB);
        check("io_ram_a", ram_a, 32'h30000);
        check("io_early_valid", {31'd0, ls_valid}, 32'd0);
        cyc(1);
        @(negedge clk);
        check("io_valid", {31'd0, ls_valid}, 32'd1);
        check("io_done_ram_wr", {31'd0, ram_wr}, 32'd0);
        wait_idle(20);
        check("io_strobes", wr_count - w0, 1);

        // Fetch and LH raised together: load first, then the fetch
        if_addr   = 32'h100;
        if_enable = 1'b1;
        issue_ls(1'b0, 3'd2, 32'h200, 32'd0, 1'b1);
        push_exp(1'b1, load_val(32'h100, 3'd4));
        scan_valid(0, 4, lk, ik);
        if_enable = 1'b0;
        scan_valid(5, 12, lk2, ik2);
        check("arb_ls_edge", lk, 3);
        check("arb_if_edge", ik2, 10);
        wait_idle(20);

        // Mispredict aborts the fetch; a store raised in the same window completes
        w0 = wr_count;
        if_addr   = 32'h100;
        if_enable = 1'b1;
        cyc(1);
        if_enable = 1'b0;
        cyc(2);
        pred_fail_flag = 1'b1;
        ls_wr_tag = 1'b1; ls_siz = 3'd4; ls_addr = 32'h500; ls_din = 32'h01020304;
        ls_enable = 1'b1;
        push_exp(1'b0, last_ls);
        cyc(1);
        @(negedge clk);
        check("abort_ram_wr", {31'd0, ram_wr}, 32'd0);
        cyc(1);
        ls_enable = 1'b0;
        cyc(2);
        pred_fail_flag = 1'b0;
        wait_idle(20);
        check("pf_sw_strobes", wr_count - w0, 4);
        check("pf_sw_mem", {mem[16'h503], mem[16'h502], mem[16'h501], mem[16'h500]}, 32'h01020304);

        // Mispredict in the fetch DONE cycle masks if_valid
        if_addr   = 32'h104;
        if_enable = 1'b1;
        cyc(1);
        if_enable = 1'b0;
        cyc(5);
        pred_fail_flag = 1'b1;
        @(negedge clk);
        check("pf_done_if_valid", {31'd0, if_valid}, 32'd0);
        cyc(1);
        pred_fail_flag = 1'b0;
        cyc(2);

        // Mispredict in IDLE blocks fetch acceptance
        if_addr = 32'h700;
        if_enable = 1'b1;
        pred_fail_flag = 1'b1;
        cyc(1);
        if_enable = 1'b0;
        pred_fail_flag = 1'b0;
        @(negedge clk);
        check("pf_idle_no_fetch", {31'd0, ram_a == 32'h700}, 32'd0);
        cyc(8);

        // rdy low for two cycles mid-LW
        issue_ls(1'b0, 3'd4, 32'h100, 32'd0, 1'b1);
        cyc(1);
        rdy = 1'b0;
        @(negedge clk);
        check("freeze_ram_wr", {31'd0, ram_wr}, 32'd0);
        cyc(2);
        rdy = 1'b1;
        scan_valid(3, 10, lk, ik);
        check("freeze_valid_edge", lk, 7);
        wait_idle(20);

        // Address wrap across 2^32
        issue_ls(1'b0, 3'd4, 32'hFFFFFFFE, 32'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ea = 32'hFFFFFFFE + k;
            check("wrap_ram_a", ram_a, ea);
            cyc(1);
        end
        wait_idle(20);

        // Reset mid-SW after two bytes
        w0 = wr_count;
        issue_ls(1'b1, 3'd4, 32'h600, 32'hCAFEF00D, 1'b0);
        cyc(2);
        rst = 1'b0;
        #1;
        check("mid_rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("mid_rst_ls_valid", {31'd0, ls_valid}, 32'd0);
        check("mid_rst_ram_a", ram_a, 32'd0);
        check("mid_rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        check("mid_rst_ls_dout", ls_dout, 32'd0);
        check("mid_rst_if_data", if_data, 32'd0);
        cyc(3);
        check("mid_rst_strobes", wr_count - w0, 2);
        check("mid_rst_mem", {8'd0, mem[16'h602], mem[16'h601], mem[16'h600]},
              {8'd0, 8'h02 ^ 8'h5A, 8'hF0, 8'h0D});
        rst = 1'b1;
        last_ls = 32'd0;
        issue_ls(1'b0, 3'd1, 32'h101, 32'd0, 1'b1);
        scan_valid(0, 5, lk, ik);
        check("post_rst_valid_edge", lk, 2);
        wait_idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
